sequence_monitor: RTL and testbench

SEQUENCE_MONITOR -- requirements
Module: sequence_monitor

---
 rtl/sequence_monitor.sv | 139 +++++++++++++
 tb/tb_sequence_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sequence_monitor.sv
// Byte-stream sequence monitor: hunts for the 0xAF sync byte, confirms lock over
// LOCK_MATCHES bytes, then flywheels through the 8-byte table counting errors and wraps.
module sequence_monitor #(
  parameter int LOCK_MATCHES = 3,
  parameter int LOSS_MISSES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       locked,
  output logic [7:0] expected,
  output logic       err,
  output logic [7:0] err_count,
  output logic [7:0] wrap_count
);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
  localparam logic [2:0] LOSS_N = 3'(LOSS_MISSES);
  localparam logic [7:0] SYNC   = 8'hAF;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] match_cnt;
  logic [2:0] miss_cnt;

  logic [2:0] idx_nxt;
  logic       hit;

  function automatic logic [7:0] seq_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'hAF;
      3'd1:    b = 8'hBC;
      3'd2:    b = 8'hE2;
      3'd3:    b = 8'h78;
      3'd4:    b = 8'hFF;
      3'd5:    b = 8'hE2;
      3'd6:    b = 8'h0B;
      default: b = 8'h8D;
    endcase
    return b;
  endfunction

  // idx is held at 0 in HUNT, so a hit there only ever means the sync byte
  // (the duplicate 0xE2 can never start CHECK).
  assign idx_nxt = idx + 3'd1;
  assign hit     = (data == seq_byte(idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      idx        <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      expected   <= SYNC;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err <= 1'b0;
      if (enable) begin
        unique case (state)
          HUNT: begin
            if (hit) begin
              state     <= CHECK;
              idx       <= 3'd1;
              match_cnt <= 4'd1;
              expected  <= seq_byte(3'd1);
            end
          end

          CHECK: begin
            if (hit) begin
              idx       <= idx_nxt;
              match_cnt <= match_cnt + 4'd1;
              expected  <= seq_byte(idx_nxt);
              if (match_cnt + 4'd1 == LOCK_N) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (data == SYNC) begin
              idx       <= 3'd1;
              match_cnt <= 4'd1;
              expected  <= seq_byte(3'd1);
            end else begin
              state     <= HUNT;
              idx       <= '0;
              match_cnt <= '0;
              expected  <= SYNC;
            end
          end

          LOCKED: begin
            if (hit) begin
              idx      <= idx_nxt;
              miss_cnt <= '0;
              expected <= seq_byte(idx_nxt);
              if (idx == 3'd7 && wrap_count != 8'hFF)
                wrap_count <= wrap_count + 8'd1;
            end else begin
              err <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              if (miss_cnt + 3'd1 == LOSS_N) begin
                state     <= HUNT;
                locked    <= 1'b0;
                idx       <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                expected  <= SYNC;
              end else begin
                idx      <= idx_nxt;
                miss_cnt <= miss_cnt + 3'd1;
                expected <= seq_byte(idx_nxt);
              end
            end
          end

          default: begin
            state    <= HUNT;
            locked   <= 1'b0;
            idx      <= '0;
            expected <= SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_monitor.sv
// Directed bench for sequence_monitor: sync/lock, false starts, flywheel errors,
// loss of lock, saturation of both counters and reset while locked.
module tb_sequence_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data;
  logic       locked;
  logic [7:0] expected;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sequence_monitor #(.LOCK_MATCHES(3), .LOSS_MISSES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data      (data),
    .locked    (locked),
    .expected  (expected),
    .err       (err),
    .err_count (err_count),
    .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic lk, input logic [7:0] ex,
                           input logic er, input logic [7:0] ec, input logic [7:0] wc);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".expected"}, 32'(expected), 32'(ex));
    check({tag, ".err"}, 32'(err), 32'(er));
    check({tag, ".err_count"}, 32'(err_count), 32'(ec));
    check({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic send(input logic [7:0] d);
    enable = 1'b1;
    data   = d;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic idle();
    enable = 1'b0;
    data   = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic send_tail();
    send(8'h78); send(8'hFF); send(8'hE2); send(8'h0B); send(8'h8D);
  endtask

  int unsigned exp_wrap;
  int unsigned exp_errc;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    data   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 5; i++) begin
      idle();
      check_all("idle", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);
    end

    // False start: AF BC then a non-sync mismatch drops back to HUNT silently.
    send(8'hAF); check_all("fs_af", 1'b0, 8'hBC, 1'b0, 8'h00, 8'h00);
    send(8'hBC); check_all("fs_bc", 1'b0, 8'hE2, 1'b0, 8'h00, 8'h00);
    send(8'h00); check_all("fs_00", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);
    // Duplicate E2 in HUNT must not sync.
    send(8'hE2); check_all("dup_e2", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);

    // AF AF BC E2: second AF restarts CHECK, then lock after E2.
    send(8'hAF); check_all("rs_af1", 1'b0, 8'hBC, 1'b0, 8'h00, 8'h00);
    send(8'hAF); check_all("rs_af2", 1'b0, 8'hBC, 1'b0, 8'h00, 8'h00);
    send(8'hBC); check_all("rs_bc", 1'b0, 8'hE2, 1'b0, 8'h00, 8'h00);
    send(8'hE2); check_all("lock", 1'b1, 8'h78, 1'b0, 8'h00, 8'h00);
    idle();      check_all("lock_hold", 1'b1, 8'h78, 1'b0, 8'h00, 8'h00);
    send_tail(); check_all("wrap1", 1'b1, 8'hAF, 1'b0, 8'h00, 8'h01);

    // Single flywheel error at idx 4.
    send(8'hAF); send(8'hBC); send(8'hE2); send(8'h78);
    check_all("pre_ff", 1'b1, 8'hFF, 1'b0, 8'h00, 8'h01);
    send(8'h00); check_all("miss1", 1'b1, 8'hE2, 1'b1, 8'h01, 8'h01);
    send(8'hE2); check_all("recover", 1'b1, 8'h0B, 1'b0, 8'h01, 8'h01);
    send(8'h0B); send(8'h8D);
    check_all("wrap2", 1'b1, 8'hAF, 1'b0, 8'h01, 8'h02);

    // Two consecutive misses lose lock; counts retained across relock.
    send(8'h00); check_all("loss1", 1'b1, 8'hBC, 1'b1, 8'h02, 8'h02);
    send(8'h00); check_all("loss2", 1'b0, 8'hAF, 1'b1, 8'h03, 8'h02);
    idle();      check_all("err_clr", 1'b0, 8'hAF, 1'b0, 8'h03, 8'h02);
    send(8'hAF); send(8'hBC); send(8'hE2);
    check_all("relock", 1'b1, 8'h78, 1'b0, 8'h03, 8'h02);
    send_tail(); check_all("wrap3", 1'b1, 8'hAF, 1'b0, 8'h03, 8'h03);

    // 300 clean sequences: wrap_count saturates.
    exp_wrap = 3;
    for (int i = 0; i < 300; i++) begin
      send(8'hAF); send(8'hBC); send(8'hE2); send_tail();
      exp_wrap = (exp_wrap < 255) ? exp_wrap + 1 : 255;
      check("wrap_sat", 32'(wrap_count), exp_wrap);
    end
    check_all("wrap_ff", 1'b1, 8'hAF, 1'b0, 8'h03, 8'hFF);

    // 300 errors in pairs, relocking between pairs: err_count saturates.
    exp_errc = 3;
    for (int i = 0; i < 150; i++) begin
      send(8'h00); send(8'h00);
      exp_errc = (exp_errc + 2 < 255) ? exp_errc + 2 : 255;
      check("err_sat", 32'(err_count), exp_errc);
      check("err_loss", 32'(locked), 32'd0);
      send(8'hAF); send(8'hBC); send(8'hE2);
      check("err_relock", 32'(locked), 32'd1);
      send_tail();
    end
    check_all("err_ff", 1'b1, 8'hAF, 1'b0, 8'hFF, 8'hFF);

    // Reset with enable=1 mid-LOCKED wins.
    send(8'hAF); send(8'hBC);
    check_all("pre_rst", 1'b1, 8'hE2, 1'b0, 8'hFF, 8'hFF);
    reset  = 1'b1;
    enable = 1'b1;
    data   = 8'hE2;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    check_all("mid_rst", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);
    send(8'hBC); check_all("post_rst", 1'b0, 8'hAF, 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
